seq_mag_comparator: RTL and testbench

//  Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, signed or unsigned.

---
 rtl/seq_mag_comparator.sv | 108 ++++++++++
 tb/tb_seq_mag_comparator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle MSB-first signed/unsigned magnitude comparator with valid/ready handshake
module seq_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  input  logic                                signed_mode,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                a_gt_b,
  output logic                                a_eq_b,
  output logic                                a_lt_b,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]    cycles,
  output logic                                busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0]    idx;
  logic             seen, first_gt;
  logic [DIGIT-1:0] sa, sb;
  logic             differ, fin;
  logic [WIDTH-1:0] msb_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign sa       = DIGIT'(ra >> (DIGIT * int'(idx)));
  assign sb       = DIGIT'(rb >> (DIGIT * int'(idx)));
  assign differ   = sa != sb;
  assign fin      = (differ && EARLY_EXIT != 0) || idx == '0;

  // State register; reset drops any in-flight compare.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // Next state and handshake outputs; start_ready is held low while in reset.
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = !rst;
        if (start_valid) state_nxt = CMP;
      end
      CMP: begin
        busy = 1'b1;
        if (fin) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit walk and result registers; the first differing digit decides the order.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ra       <= '0;
      rb       <= '0;
      idx      <= '0;
      seen     <= 1'b0;
      first_gt <= 1'b0;
      a_gt_b   <= 1'b0;
      a_eq_b   <= 1'b0;
      a_lt_b   <= 1'b0;
      cycles   <= '0;
    end else if (state == IDLE && start_valid) begin
      ra       <= a ^ msb_flip;
      rb       <= b ^ msb_flip;
      idx      <= IW'(N - 1);
      seen     <= 1'b0;
      first_gt <= 1'b0;
    end else if (state == CMP) begin
      if (!seen && differ) begin
        seen     <= 1'b1;
        first_gt <= sa > sb;
      end
      if (fin) begin
        a_gt_b <= seen ? first_gt : sa > sb;
        a_lt_b <= seen ? !first_gt : sa < sb;
        a_eq_b <= !seen && !differ;
        cycles <= CW'(N) - CW'(idx);
      end else begin
        idx <= idx - IW'(1);
      end
    end
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed-table and model-checked bench for seq_mag_comparator (early and full-walk variants)
module tb_seq_mag_comparator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       sm = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sr1, rv1, gt1, eq1, lt1, bz1;
  logic       sr0, rv0, gt0, eq0, lt0, bz0;
  logic [2:0] cy1, cy0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_e1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1), .a(a), .b(b),
    .signed_mode(sm), .res_valid(rv1), .res_ready(res_ready), .a_gt_b(gt1), .a_eq_b(eq1),
    .a_lt_b(lt1), .cycles(cy1), .busy(bz1)
  );

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_e0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0), .a(a), .b(b),
    .signed_mode(sm), .res_valid(rv0), .res_ready(res_ready), .a_gt_b(gt0), .a_eq_b(eq0),
    .a_lt_b(lt0), .cycles(cy0), .busy(bz0)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [2:0] f;
    int         c1;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y, input logic s);
    if (s) return ($signed(x) > $signed(y)) ? 3'b100 : ($signed(x) == $signed(y)) ? 3'b010 : 3'b001;
    return (x > y) ? 3'b100 : (x == y) ? 3'b010 : 3'b001;
  endfunction

  function automatic int ref_cycles(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x ^ y;
    for (int k = 3; k >= 0; k--)
      if (d[2*k +: 2] != 2'b00) return 4 - k;
    return 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic ts);
    a = ta;
    b = tb_;
    sm = ts;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    sm = 1'($urandom);
  endtask

  task automatic collect(input string tag, input logic [2:0] ef, input int ec1);
    int n, l1, l0;
    n = 0;
    l1 = 0;
    l0 = 0;
    while ((l1 == 0 || l0 == 0) && n < 20) begin
      step();
      n++;
      if (l1 == 0 && rv1) l1 = n;
      if (l0 == 0 && rv0) l0 = n;
    end
    chk({tag, " lat_early"}, l1, ec1);
    chk({tag, " lat_full"}, l0, 4);
    chk({tag, " flags_early"}, {gt1, eq1, lt1}, ef);
    chk({tag, " flags_full"}, {gt0, eq0, lt0}, ef);
    chk({tag, " cycles_early"}, cy1, ec1);
    chk({tag, " cycles_full"}, cy0, 4);
  endtask

  task automatic retire(input string tag);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, " idle_after_retire"}, {sr1, sr0, rv1, rv0, bz1, bz0}, 6'b110000);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{8'h35, 8'h53, 1'b0, 3'b001, 1};
    tbl[1]  = '{8'hA7, 8'hA7, 1'b0, 3'b010, 4};
    tbl[2]  = '{8'h0E, 8'h0D, 1'b0, 3'b100, 4};
    tbl[3]  = '{8'hFF, 8'h01, 1'b1, 3'b001, 1};
    tbl[4]  = '{8'hFF, 8'h01, 1'b0, 3'b100, 1};
    tbl[5]  = '{8'h80, 8'h7F, 1'b1, 3'b001, 1};
    tbl[6]  = '{8'h80, 8'h80, 1'b1, 3'b010, 4};
    tbl[7]  = '{8'h7F, 8'h80, 1'b1, 3'b100, 1};
    tbl[8]  = '{8'h12, 8'h13, 1'b0, 3'b001, 4};
    tbl[9]  = '{8'h40, 8'h30, 1'b0, 3'b100, 1};
    tbl[10] = '{8'h05, 8'h06, 1'b1, 3'b001, 4};
    tbl[11] = '{8'hF0, 8'hF4, 1'b1, 3'b001, 3};

    #1;
    chk("reset_outputs_early", {sr1, rv1, gt1, eq1, lt1, cy1, bz1}, 0);
    chk("reset_outputs_full", {sr0, rv0, gt0, eq0, lt0, cy0, bz0}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ready_after_reset", {sr1, sr0, rv1, rv0}, 4'b1100);

    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_ready_idle_no_effect", {sr1, sr0, rv1, rv0, bz1, bz0}, 6'b110000);

    foreach (tbl[i]) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].s);
      collect($sformatf("vec%0d", i), tbl[i].f, tbl[i].c1);
      retire($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra ^ 8'(1 << $urandom_range(7, 0)) : 8'($urandom);
      rs = 1'(i);
      launch(ra, rb, rs);
      collect($sformatf("rnd%0d", i), ref_flags(ra, rb, rs), ref_cycles(ra, rb));
      retire($sformatf("rnd%0d", i));
    end

    launch(8'h35, 8'h53, 1'b0);
    collect("bp", 3'b001, 1);
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1;
      a = 8'h0E;
      b = 8'h0D;
      step();
      chk($sformatf("bp_hold%0d_early", i), {rv1, sr1, gt1, eq1, lt1, cy1}, {1'b1, 1'b0, 3'b001, 3'd1});
      chk($sformatf("bp_hold%0d_full", i), {rv0, sr0, gt0, eq0, lt0, cy0}, {1'b1, 1'b0, 3'b001, 3'd4});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_retire_no_accept", {rv1, rv0, sr1, sr0, bz1, bz0}, 6'b001100);
    launch(8'h0E, 8'h0D, 1'b0);
    chk("bp_next_accepted", {bz1, bz0, sr1, sr0}, 4'b1100);
    collect("bp_next", 3'b100, 4);
    retire("bp_next");

    launch(8'hA7, 8'hA7, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_early", {sr1, rv1, gt1, eq1, lt1, cy1, bz1}, 0);
    chk("midrst_full", {sr0, rv0, gt0, eq0, lt0, cy0, bz0}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("midrst_release", {sr1, sr0, rv1, rv0, bz1, bz0}, 6'b110000);
    step();
    chk("midrst_no_stale", {rv1, rv0}, 0);
    launch(8'h40, 8'h30, 1'b0);
    collect("post_rst", 3'b100, 1);
    retire("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
